// File: rtl/gtp_tx_arb.sv
// Round-robin scheduler sharing one GTP TX packetizer between NUM_SRC packet
// sources and a trigger source; completion is taken from the TX AXI-Stream handshake.
module gtp_tx_arb #(
  parameter  int unsigned NUM_SRC     = 4,
  parameter  int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned SELW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                   log_clk,
  input  logic                   log_rst_q,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [32*NUM_SRC-1:0]  src_gtxid,
  input  logic [32*NUM_SRC-1:0]  src_head,
  output logic [NUM_SRC-1:0]     src_gnt,
  output logic [NUM_SRC-1:0]     src_done,
  input  logic                   trig_req,
  output logic                   trig_done,
  output logic                   tx_packet_req,
  output logic                   tx_packet_trigger,
  output logic [31:0]            tx_packet_gtxid,
  output logic [31:0]            tx_packet_head,
  input  logic                   tx_tvalid,
  input  logic                   tx_tready,
  input  logic                   tx_tlast,
  input  logic                   tx_link_up,
  output logic [SELW-1:0]        src_sel,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int unsigned WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic                 trig_pend_q, trig_pend_d;
  logic                 is_trig_q, is_trig_d;
  logic [SELW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [NUM_SRC-1:0]   gnt_q, gnt_d;
  logic [NUM_SRC-1:0]   done_q, done_d;
  logic                 trig_done_q, trig_done_d;
  logic                 req_q, req_d;
  logic                 trig_q, trig_d;
  logic [31:0]          gtxid_q, gtxid_d;
  logic [31:0]          head_q, head_d;
  logic [SELW-1:0]      sel_q, sel_d;
  logic                 tmo_q, tmo_d;

  logic                 beat, pkt_end;
  logic [2*NUM_SRC-1:0] req2;
  logic [NUM_SRC-1:0]   req_rot;
  logic                 win_vld;
  logic [SELW-1:0]      win_idx;
  logic [NUM_SRC-1:0]   win_oh;
  logic [31:0]          win_gtxid, win_head;
  logic [NUM_SRC-1:0]   sel_oh;
  int unsigned          pos;

  assign beat    = tx_tvalid & tx_tready;
  assign pkt_end = beat & tx_tlast;

  // Rotate the request vector so bit 0 is the source just after rr_ptr;
  // the first set bit is then the round-robin winner.
  always_comb begin
    req2    = {src_req, src_req};
    req_rot = NUM_SRC'(req2 >> (32'(rr_ptr_q) + 32'd1));
    win_vld = 1'b0;
    win_idx = '0;
    pos     = 0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (!win_vld && req_rot[j]) begin
        win_vld = 1'b1;
        pos     = 32'(rr_ptr_q) + 32'd1 + j;
        if (pos >= NUM_SRC) pos = pos - NUM_SRC;
        win_idx = SELW'(pos);
      end
    end
  end

  always_comb begin
    win_oh    = '0;
    sel_oh    = '0;
    win_gtxid = '0;
    win_head  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      win_oh[i] = (win_idx == SELW'(i));
      sel_oh[i] = (sel_q == SELW'(i));
      if (win_oh[i]) begin
        win_gtxid = src_gtxid[32*i +: 32];
        win_head  = src_head[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    trig_pend_d = trig_pend_q;
    is_trig_d   = is_trig_q;
    rr_ptr_d    = rr_ptr_q;
    wd_d        = wd_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    trig_done_d = 1'b0;
    req_d       = req_q;
    trig_d      = trig_q;
    gtxid_d     = gtxid_q;
    head_d      = head_q;
    sel_d       = sel_q;
    tmo_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_link_up && tx_tready && (trig_pend_q || win_vld)) begin
          state_d = S_START;
          wd_d    = '0;
          if (trig_pend_q) begin
            trig_d      = 1'b1;
            is_trig_d   = 1'b1;
            trig_pend_d = 1'b0;
            gnt_d       = '0;
            gtxid_d     = '0;
            head_d      = '0;
          end else begin
            req_d     = 1'b1;
            is_trig_d = 1'b0;
            gnt_d     = win_oh;
            sel_d     = win_idx;
            rr_ptr_d  = win_idx;
            gtxid_d   = win_gtxid;
            head_d    = win_head;
          end
        end
      end
      S_START, S_BUSY: begin
        if (beat) begin
          req_d  = 1'b0;
          trig_d = 1'b0;
          wd_d   = '0;
          if (pkt_end) begin
            state_d = S_DONE;
            if (is_trig_q) trig_done_d = 1'b1;
            else           done_d      = sel_oh;
          end else begin
            state_d = S_BUSY;
          end
        end else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          req_d   = 1'b0;
          trig_d  = 1'b0;
          gnt_d   = '0;
          gtxid_d = '0;
          head_d  = '0;
          state_d = S_GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        gtxid_d = '0;
        head_d  = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A trigger arriving on the grant cycle stays pending for the next frame.
    if (trig_req) trig_pend_d = 1'b1;
  end

  always_ff @(posedge log_clk) begin
    if (log_rst_q) begin
      state_q     <= S_IDLE;
      trig_pend_q <= 1'b0;
      is_trig_q   <= 1'b0;
      rr_ptr_q    <= SELW'(NUM_SRC - 1);
      wd_q        <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      trig_done_q <= 1'b0;
      req_q       <= 1'b0;
      trig_q      <= 1'b0;
      gtxid_q     <= '0;
      head_q      <= '0;
      sel_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_pend_q <= trig_pend_d;
      is_trig_q   <= is_trig_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_q        <= wd_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      trig_done_q <= trig_done_d;
      req_q       <= req_d;
      trig_q      <= trig_d;
      gtxid_q     <= gtxid_d;
      head_q      <= head_d;
      sel_q       <= sel_d;
      tmo_q       <= tmo_d;
    end
  end

  assign src_gnt           = gnt_q;
  assign src_done          = done_q;
  assign trig_done         = trig_done_q;
  assign tx_packet_req     = req_q;
  assign tx_packet_trigger = trig_q;
  assign tx_packet_gtxid   = gtxid_q;
  assign tx_packet_head    = head_q;
  assign src_sel           = sel_q;
  assign busy              = (state_q != S_IDLE);
  assign timeout_err       = tmo_q;

endmodule

// File: tb/tb_gtp_tx_arb.sv
// Directed self-checking bench for gtp_tx_arb (4 sources, 16-cycle watchdog).
module tb_gtp_tx_arb;

  logic         log_clk = 1'b0;
  logic         log_rst_q;
  logic [3:0]   src_req;
  logic [127:0] src_gtxid;
  logic [127:0] src_head;
  logic [3:0]   src_gnt;
  logic [3:0]   src_done;
  logic         trig_req;
  logic         trig_done;
  logic         tx_packet_req;
  logic         tx_packet_trigger;
  logic [31:0]  tx_packet_gtxid;
  logic [31:0]  tx_packet_head;
  logic         tx_tvalid;
  logic         tx_tready;
  logic         tx_tlast;
  logic         tx_link_up;
  logic [1:0]   src_sel;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  gtp_tx_arb #(
    .NUM_SRC     (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .log_clk           (log_clk),
    .log_rst_q         (log_rst_q),
    .src_req           (src_req),
    .src_gtxid         (src_gtxid),
    .src_head          (src_head),
    .src_gnt           (src_gnt),
    .src_done          (src_done),
    .trig_req          (trig_req),
    .trig_done         (trig_done),
    .tx_packet_req     (tx_packet_req),
    .tx_packet_trigger (tx_packet_trigger),
    .tx_packet_gtxid   (tx_packet_gtxid),
    .tx_packet_head    (tx_packet_head),
    .tx_tvalid         (tx_tvalid),
    .tx_tready         (tx_tready),
    .tx_tlast          (tx_tlast),
    .tx_link_up        (tx_link_up),
    .src_sel           (src_sel),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  always #5 log_clk = ~log_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge log_clk);
    #1;
  endtask

  task automatic do_pkt(input int nbeats);
    tx_tvalid = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      tx_tlast = (b == nbeats - 1);
      tick();
    end
    tx_tvalid = 1'b0;
    tx_tlast  = 1'b0;
  endtask

  function automatic logic [31:0] exp_gtxid(input int i);
    case (i)
      0:       return 32'h0000_00AA;
      1:       return 32'h0000_0011;
      2:       return 32'h0000_0022;
      default: return 32'h0000_0033;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL sim_timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int order [6] = '{0, 1, 2, 3, 0, 1};

    log_rst_q  = 1'b1;
    src_req    = '0;
    trig_req   = 1'b0;
    tx_tvalid  = 1'b0;
    tx_tlast   = 1'b0;
    tx_tready  = 1'b1;
    tx_link_up = 1'b1;
    src_gtxid  = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h0000_00AA};
    src_head   = {32'h0000_0304, 32'h0000_0204, 32'h0000_0104, 32'h0000_0004};
    tick();
    tick();
    check("rst_gnt",   64'(src_gnt), 64'h0);
    check("rst_req",   64'(tx_packet_req), 64'h0);
    check("rst_busy",  64'(busy), 64'h0);
    check("rst_head",  64'(tx_packet_head), 64'h0);
    check("rst_tmo",   64'(timeout_err), 64'h0);
    log_rst_q = 1'b0;

    // Single packet from source 1
    src_req = 4'b0010;
    tick();
    check("p1_gnt",   64'(src_gnt), 64'h2);
    check("p1_req",   64'(tx_packet_req), 64'h1);
    check("p1_sel",   64'(src_sel), 64'h1);
    check("p1_gtxid", 64'(tx_packet_gtxid), 64'h11);
    check("p1_head",  64'(tx_packet_head), 64'h104);
    check("p1_busy",  64'(busy), 64'h1);
    tx_tvalid = 1'b1;
    tx_tlast  = 1'b0;
    tick();
    check("p1_req_drop", 64'(tx_packet_req), 64'h0);
    check("p1_head_b1",  64'(tx_packet_head), 64'h104);
    tick();
    check("p1_gnt_b2",   64'(src_gnt), 64'h2);
    tx_tlast = 1'b1;
    tick();
    check("p1_done",     64'(src_done), 64'h2);
    check("p1_head_dn",  64'(tx_packet_head), 64'h104);
    tx_tvalid = 1'b0;
    tx_tlast  = 1'b0;
    src_req   = 4'b0000;
    tick();
    check("p1_gap_done", 64'(src_done), 64'h0);
    check("p1_gap_gnt",  64'(src_gnt), 64'h0);
    check("p1_gap_head", 64'(tx_packet_head), 64'h0);
    check("p1_gap_busy", 64'(busy), 64'h1);
    tick();
    check("p1_idle_busy", 64'(busy), 64'h0);

    // Round robin with all sources requesting, starting from reset
    log_rst_q = 1'b1;
    tick();
    check("rr_rst_busy", 64'(busy), 64'h0);
    src_req   = 4'b1111;
    log_rst_q = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_gnt",   64'(src_gnt), 64'(4'b0001 << order[k]));
      check("rr_sel",   64'(src_sel), 64'(order[k]));
      check("rr_gtxid", 64'(tx_packet_gtxid), 64'(exp_gtxid(order[k])));
      do_pkt(2);
      check("rr_done",  64'(src_done), 64'(4'b0001 << order[k]));
      if (k == 5) src_req = 4'b0000;
      tick();
      tick();
    end

    // Trigger pending while tready low; it wins over source 0
    tx_tready = 1'b0;
    trig_req  = 1'b1;
    src_req   = 4'b0001;
    tick();
    check("tr_nogrant_busy", 64'(busy), 64'h0);
    check("tr_nogrant_trig", 64'(tx_packet_trigger), 64'h0);
    trig_req  = 1'b0;
    tx_tready = 1'b1;
    tick();
    check("tr_trig", 64'(tx_packet_trigger), 64'h1);
    check("tr_req",  64'(tx_packet_req), 64'h0);
    check("tr_gnt",  64'(src_gnt), 64'h0);
    do_pkt(1);
    check("tr_done",      64'(trig_done), 64'h1);
    check("tr_trig_drop", 64'(tx_packet_trigger), 64'h0);
    check("tr_src_done",  64'(src_done), 64'h0);
    tick();
    check("tr_done_pulse", 64'(trig_done), 64'h0);
    tick();
    tick();
    check("tr_s0_gnt", 64'(src_gnt), 64'h1);
    check("tr_s0_req", 64'(tx_packet_req), 64'h1);
    do_pkt(1);
    check("tr_s0_done", 64'(src_done), 64'h1);
    src_req = 4'b0000;
    tick();
    tick();

    // Link down / tready low blocks a grant
    tx_link_up = 1'b0;
    src_req    = 4'b0100;
    tick();
    check("lk_down_busy", 64'(busy), 64'h0);
    tick();
    check("lk_down_gnt", 64'(src_gnt), 64'h0);
    tx_link_up = 1'b1;
    tx_tready  = 1'b0;
    tick();
    check("lk_trdy_busy", 64'(busy), 64'h0);
    tx_tready = 1'b1;
    tick();
    check("lk_gnt", 64'(src_gnt), 64'h4);
    check("lk_sel", 64'(src_sel), 64'h2);
    do_pkt(1);
    check("lk_done", 64'(src_done), 64'h4);
    src_req = 4'b0000;
    tick();
    tick();

    // Watchdog: three beats then tready stuck low
    src_req = 4'b1001;
    tick();
    check("wd_gnt", 64'(src_gnt), 64'h8);
    tx_tvalid = 1'b1;
    tx_tlast  = 1'b0;
    tick();
    tick();
    tick();
    tx_tready = 1'b0;
    for (int s = 0; s < 15; s++) tick();
    check("wd_pre_tmo", 64'(timeout_err), 64'h0);
    check("wd_pre_gnt", 64'(src_gnt), 64'h8);
    tick();
    check("wd_tmo",      64'(timeout_err), 64'h1);
    check("wd_tmo_gnt",  64'(src_gnt), 64'h0);
    check("wd_tmo_req",  64'(tx_packet_req), 64'h0);
    check("wd_tmo_done", 64'(src_done), 64'h0);
    tx_tvalid = 1'b0;
    tx_tready = 1'b1;
    tick();
    check("wd_tmo_pulse", 64'(timeout_err), 64'h0);
    check("wd_idle_busy", 64'(busy), 64'h0);
    tick();
    check("wd_next_gnt", 64'(src_gnt), 64'h1);

    // Reset in the middle of a packet
    tx_tvalid = 1'b1;
    tick();
    check("mr_busy", 64'(busy), 64'h1);
    tx_tvalid = 1'b0;
    log_rst_q = 1'b1;
    tick();
    check("mr_gnt",   64'(src_gnt), 64'h0);
    check("mr_req",   64'(tx_packet_req), 64'h0);
    check("mr_busy0", 64'(busy), 64'h0);
    check("mr_gtxid", 64'(tx_packet_gtxid), 64'h0);
    src_req   = 4'b1000;
    log_rst_q = 1'b0;
    tick();
    check("mr_s3_gnt", 64'(src_gnt), 64'h8);
    check("mr_s3_sel", 64'(src_sel), 64'h3);
    do_pkt(1);
    check("mr_s3_done", 64'(src_done), 64'h8);
    src_req = 4'b0000;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gtp_tx_arb.md
Name: gtp_tx_arb

Overview:
Round-robin scheduler that shares one GTP TX packetizer between NUM_SRC packet sources and one trigger source.
- Latches the winner's gtxid/head and holds them stable for the whole packet.
- Drives the packetizer's req/trigger inputs.
- Detects packet completion by monitoring the packetizer's AXI-Stream TX handshake.
- Sits between the per-channel packet builders and the GTP TX packetizer in the log_clk domain.

Parameters:
NUM_SRC, 4, number of packet requesters (1..8).
TIMEOUT_CYC, 1024, stall watchdog limit: consecutive cycles without a tx beat while a packet is in flight.
SELW, derived, max(1, clog2(NUM_SRC)); width of src_sel.

Ports:
log_clk  in  1  clock
log_rst_q  in  1  reset, synchronous, active-high
src_req  in  NUM_SRC  per-source packet request, level, held until src_done
src_gtxid  in  32*NUM_SRC  per-source gtxid word; source i at bits [32i+31:32i]
src_head  in  32*NUM_SRC  per-source header/length word; [7:0]=data length, [15:8]=start addr
src_gnt  out  NUM_SRC  one-hot grant, high from grant to done
src_done  out  NUM_SRC  1-cycle pulse on packet completion
trig_req  in  1  trigger request pulse
trig_done  out  1  1-cycle pulse when trigger frame completes
tx_packet_req  out  1  to packetizer: start data packet
tx_packet_trigger  out  1  to packetizer: start trigger frame
tx_packet_gtxid  out  32  to packetizer, registered
tx_packet_head  out  32  to packetizer, registered
tx_tvalid  in  1  monitor of packetizer s_axi_tx_tvalid
tx_tready  in  1  monitor of s_axi_tx_tready
tx_tlast  in  1  monitor of s_axi_tx_tlast
tx_link_up  in  1  channel up; no new grant while low
src_sel  out  SELW  index of granted source (valid while any src_gnt bit is high)
busy  out  1  high in any state except IDLE
timeout_err  out  1  1-cycle pulse on watchdog expiry

Behaviour:
- Reset (sync): state=IDLE, all outputs 0, trig_pend=0, rr_ptr=NUM_SRC-1 (so source 0 wins first), watchdog=0. Reset mid-packet drops all outputs on the next edge. Packetizer reset is handled separately.
- beat = tx_tvalid & tx_tready. end = beat & tx_tlast.
- trig_pend is set by trig_req and cleared on trigger grant. If set and clear coincide, set wins. Multiple trig_req pulses while pending merge into one.
- IDLE: arbitration requires tx_link_up & tx_tready & (trig_pend | |src_req).
  - trig_pend has strict priority over packets.
  - Otherwise, search src_req from rr_ptr+1 upward, wrapping modulo NUM_SRC; first set bit wins.
  - On grant at edge t, all of the following take effect at t+1:
    - register src_sel, src_gnt, tx_packet_gtxid and tx_packet_head from the winner's slices;
    - assert tx_packet_req (or tx_packet_trigger for a trigger grant);
    - update rr_ptr to the winner (rr_ptr is unchanged by trigger grants);
    - go to START.
- START: hold req/trigger high until the first beat, then deassert on the next edge and go to BUSY. If that first beat is also end, go straight to DONE.
- BUSY: hold gtxid/head/gnt stable. On end, go to DONE.
- DONE (1 cycle):
  - pulse src_done[src_sel] (or trig_done);
  - clear src_gnt and set tx_packet_gtxid/tx_packet_head to 0;
  - go to GAP.
- GAP (1 cycle): guarantees the packetizer re-enters its IDLE before the next req. Then go to IDLE.
- src_req of the granted source is ignored from grant until done. A source still requesting at IDLE is re-arbitrated in normal round-robin order. Deassertion of a non-granted src_req before grant is not an error.
- Watchdog (START/BUSY only):
  - count cycles without a beat; a beat clears the count;
  - at count == TIMEOUT_CYC-1, pulse timeout_err, drop req/trigger/gnt, go to GAP;
  - no src_done/trig_done is issued on timeout; rr_ptr keeps the winner.
- tx_link_up falling mid-packet has no effect; only the watchdog aborts.

Test Plan:
- src_req=4'b0010, gtxid1=0x00000011, head1=0x00000104, tready=1 → src_gnt=0010 and tx_packet_req at t+1; req drops after first beat; head=0x104 held until done; src_done[1] pulses on the tlast beat; busy low 2 cycles after done.
- src_req=4'b1111 held, each packet completed → grant order 0,1,2,3,0,1; src_sel matches each grant.
- trig_req pulse in the same cycle as src_req=4'b0001 → tx_packet_trigger first, trig_done on the tlast beat, then src 0 granted after GAP; rr_ptr unaffected by the trigger.
- tready=0 or tx_link_up=0 in IDLE with requests pending → no grant, busy=0; grant on the first cycle both are high.
- TIMEOUT_CYC=16, tready forced low after 3 beats → timeout_err at the 16th stall cycle, gnt/req low, no src_done, next grant goes to the next source.
- Reset asserted mid-BUSY → all outputs 0 after one edge; after reset release with src_req=4'b1000, source 3 is granted.
